// File: rtl/uart_autobaud.sv
// Baud-rate detector: times a 0x55 sync character on rx and reports the nearest standard rate.
// Define AUTOBAUD_GLITCH_FILTER_EN to insert a 3-sample majority filter ahead of edge detection.
module uart_autobaud #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int CNT_W       = 15,
   parameter int TIMEOUT_CYC = 25000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             locked,
   output logic             err,
   output logic [16:0]      baud,
   output logic [CNT_W-1:0] bit_cycles
);
   // state       | meaning
   // S_IDLE      | waiting for an accepted start
   // S_WAIT_HIGH | discarding any character in flight until the line idles high
   // S_WAIT_FALL | waiting for the start-bit falling edge (edge 0)
   // S_MEASURE   | timing edges 1..9, window and timeout checks
   // S_EVAL      | rounding the bit period and matching it to a standard rate
   typedef enum logic [2:0] {S_IDLE, S_WAIT_HIGH, S_WAIT_FALL, S_MEASURE, S_EVAL} state_t;

   localparam int TOT_W = CNT_W + 4;
   localparam int BCW   = TOT_W + 1;
   localparam logic [31:0] N0 = 32'(CLK_FREQ_HZ / 4800);
   localparam logic [31:0] N1 = 32'(CLK_FREQ_HZ / 9600);
   localparam logic [31:0] N2 = 32'(CLK_FREQ_HZ / 14400);
   localparam logic [31:0] N3 = 32'(CLK_FREQ_HZ / 19200);
   localparam logic [31:0] N4 = 32'(CLK_FREQ_HZ / 38400);
   localparam logic [31:0] N5 = 32'(CLK_FREQ_HZ / 57600);
   localparam logic [31:0] N6 = 32'(CLK_FREQ_HZ / 115200);
   localparam logic [31:0] N7 = 32'(CLK_FREQ_HZ / 128000);
   localparam logic [31:0] M0 = (N0 + N1) >> 1;
   localparam logic [31:0] M1 = (N1 + N2) >> 1;
   localparam logic [31:0] M2 = (N2 + N3) >> 1;
   localparam logic [31:0] M3 = (N3 + N4) >> 1;
   localparam logic [31:0] M4 = (N4 + N5) >> 1;
   localparam logic [31:0] M5 = (N5 + N6) >> 1;
   localparam logic [31:0] M6 = (N6 + N7) >> 1;
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);

   state_t r_state, w_state_nxt;

   logic r_rx_s1, r_rx_s2, r_line_d;
   logic w_line, w_edge, w_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= rx;
         r_rx_s2 <= r_rx_s1;
      end
   end

`ifdef AUTOBAUD_GLITCH_FILTER_EN
   logic r_h1, r_h2, r_filt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h1   <= 1'b1;
         r_h2   <= 1'b1;
         r_filt <= 1'b1;
      end else begin
         r_h1   <= r_rx_s2;
         r_h2   <= r_h1;
         r_filt <= (r_rx_s2 & r_h1) | (r_rx_s2 & r_h2) | (r_h1 & r_h2);
      end
   end
   assign w_line = r_filt;
`else
   assign w_line = r_rx_s2;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_line_d <= 1'b1;
      else     r_line_d <= w_line;
   end

   assign w_edge = r_line_d ^ w_line;
   assign w_fall = r_line_d & ~w_line;

   logic [CNT_W-1:0] r_int_cnt, r_ref;
   logic [TOT_W-1:0] r_tot_cnt, r_total;
   logic [3:0]       r_edge_idx;
   logic [CNT_W:0]   w_win_lo, w_win_hi;
   logic             w_in_win, w_timeout, w_tot_sat, w_meas_err, w_last_edge;

   assign w_win_lo    = {1'b0, r_ref} - {3'b000, r_ref[CNT_W-1:2]};
   assign w_win_hi    = {1'b0, r_ref} + {3'b000, r_ref[CNT_W-1:2]};
   assign w_in_win    = ({1'b0, r_int_cnt} >= w_win_lo) && ({1'b0, r_int_cnt} <= w_win_hi);
   assign w_timeout   = r_int_cnt >= TO_CNT;
   assign w_tot_sat   = (r_edge_idx <= 4'd8) && (&r_tot_cnt);
   // Edge 1 only defines the reference interval, so it is exempt from the window test.
   assign w_meas_err  = (w_edge && (r_edge_idx != 4'd1) && !w_in_win)
                      || (!w_edge && w_timeout) || w_tot_sat;
   assign w_last_edge = w_edge && (r_edge_idx == 4'd9);

   logic [BCW-1:0]   w_bc_full;
   logic [CNT_W-1:0] w_bc;
   logic [31:0]      w_bc32, w_nom, w_diff;
   logic [16:0]      w_sel_baud;
   logic             w_eval_err;

   assign w_bc_full = ({1'b0, r_total} + BCW'(4)) >> 3;
   assign w_bc      = (|w_bc_full[BCW-1:CNT_W]) ? '1 : w_bc_full[CNT_W-1:0];
   assign w_bc32    = 32'(w_bc);

   always_comb begin
      w_sel_baud = 17'd128000;
      w_nom      = N7;
      if      (w_bc32 >= M0) begin w_sel_baud = 17'd4800;   w_nom = N0; end
      else if (w_bc32 >= M1) begin w_sel_baud = 17'd9600;   w_nom = N1; end
      else if (w_bc32 >= M2) begin w_sel_baud = 17'd14400;  w_nom = N2; end
      else if (w_bc32 >= M3) begin w_sel_baud = 17'd19200;  w_nom = N3; end
      else if (w_bc32 >= M4) begin w_sel_baud = 17'd38400;  w_nom = N4; end
      else if (w_bc32 >= M5) begin w_sel_baud = 17'd57600;  w_nom = N5; end
      else if (w_bc32 >= M6) begin w_sel_baud = 17'd115200; w_nom = N6; end
   end

   assign w_diff     = (w_bc32 >= w_nom) ? (w_bc32 - w_nom) : (w_nom - w_bc32);
   assign w_eval_err = w_diff > (w_nom >> 4);

   logic w_accept, w_meas_start, w_measuring, w_fin_ok, w_fin_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (w_accept) w_state_nxt = S_WAIT_HIGH;
         S_WAIT_HIGH: if (w_line)   w_state_nxt = S_WAIT_FALL;
         S_WAIT_FALL: if (w_fall)   w_state_nxt = S_MEASURE;
         S_MEASURE: begin
            if (w_meas_err)       w_state_nxt = S_IDLE;
            else if (w_last_edge) w_state_nxt = S_EVAL;
         end
         S_EVAL:      w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept     = 1'b0;
      w_meas_start = 1'b0;
      w_measuring  = 1'b0;
      w_fin_ok     = 1'b0;
      w_fin_err    = 1'b0;
      case (r_state)
         S_IDLE:      w_accept     = start && !done;
         S_WAIT_FALL: w_meas_start = w_fall;
         S_MEASURE: begin
            w_measuring = 1'b1;
            w_fin_err   = w_meas_err;
         end
         S_EVAL: begin
            w_fin_ok  = !w_eval_err;
            w_fin_err = w_eval_err;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int_cnt  <= '0;
         r_tot_cnt  <= '0;
         r_total    <= '0;
         r_ref      <= '0;
         r_edge_idx <= '0;
      end else if (w_meas_start) begin
         r_int_cnt  <= CNT_W'(1);
         r_tot_cnt  <= TOT_W'(1);
         r_edge_idx <= 4'd1;
      end else if (w_measuring) begin
         if (w_edge) begin
            r_int_cnt  <= CNT_W'(1);
            r_edge_idx <= r_edge_idx + 4'd1;
            if (r_edge_idx == 4'd1) r_ref   <= r_int_cnt;
            if (r_edge_idx == 4'd8) r_total <= r_tot_cnt;
         end else if (!(&r_int_cnt)) begin
            r_int_cnt <= r_int_cnt + CNT_W'(1);
         end
         if ((r_edge_idx <= 4'd8) && !(&r_tot_cnt))
            r_tot_cnt <= r_tot_cnt + TOT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
         baud       <= 17'd9600;
         bit_cycles <= '0;
      end else begin
         done <= w_fin_ok | w_fin_err;
         if (w_accept) begin
            busy   <= 1'b1;
            locked <= 1'b0;
            err    <= 1'b0;
         end else if (w_fin_ok) begin
            busy       <= 1'b0;
            locked     <= 1'b1;
            baud       <= w_sel_baud;
            bit_cycles <= w_bc;
         end else if (w_fin_err) begin
            busy   <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud; the DUT runs at a nominal 10 MHz so the slow rates stay short.
// Nominal cycles/bit at 10 MHz: 4800=2083 9600=1041 38400=260 57600=173 115200=86.
module tb_uart_autobaud;
   logic        clk = 1'b0;
   logic        rst, rx, start;
   logic        busy, done, locked, err;
   logic [16:0] baud;
   logic [14:0] bit_cycles;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [16:0] cap_baud;
   logic        cap_locked, cap_err, cap_busy;

   uart_autobaud #(
      .CLK_FREQ_HZ(10_000_000),
      .CNT_W(15),
      .TIMEOUT_CYC(2500)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .start(start),
      .busy(busy),
      .done(done),
      .locked(locked),
      .err(err),
      .baud(baud),
      .bit_cycles(bit_cycles)
   );

   always #5 clk = ~clk;

   // Counts every cycle done is high, so a stretched pulse shows up as an extra count.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt   = done_cnt + 1;
         cap_baud   = baud;
         cap_locked = locked;
         cap_err    = err;
         cap_busy   = busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic arm();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int cyc);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (cyc) @(negedge clk);
      end
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt < exp_done; i++) @(negedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_baud", baud, 9600);
      chk("rst_bit_cycles", bit_cycles, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 0x55 at 115200
      arm();
      chk("busy_after_start", busy, 1);
      exp_done++;
      send_byte(8'h55, 86);
      wait_done(200);
      chk("b115200_done_cnt", done_cnt, exp_done);
      chk("b115200_baud", cap_baud, 115200);
      chk("b115200_locked", cap_locked, 1);
      chk("b115200_err", cap_err, 0);
      chk("b115200_busy_at_done", cap_busy, 0);
      chk("b115200_bit_cycles", bit_cycles, 86);
      chk("b115200_done_low", done, 0);

      // 9600 running 3% fast; a start coinciding with done must be ignored
      arm();
      exp_done++;
      fork
         send_byte(8'h55, 1010);
         begin
            for (int i = 0; i < 20000 && done !== 1'b1; i++) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("start_at_done_ignored", busy, 0);
         end
      join
      wait_done(100);
      chk("b9600f_done_cnt", done_cnt, exp_done);
      chk("b9600f_baud", cap_baud, 9600);
      chk("b9600f_locked", cap_locked, 1);
      chk("b9600f_bit_cycles", bit_cycles, 1010);

      // 0x55 at 4800
      arm();
      exp_done++;
      send_byte(8'h55, 2083);
      wait_done(200);
      chk("b4800_done_cnt", done_cnt, exp_done);
      chk("b4800_baud", cap_baud, 4800);
      chk("b4800_locked", cap_locked, 1);
      chk("b4800_err", cap_err, 0);
      chk("b4800_bit_cycles", bit_cycles, 2083);

      // 960 cyc/bit: nearest is 9600 (1041) but 81 off exceeds 1041/16
      arm();
      exp_done++;
      send_byte(8'h55, 960);
      wait_done(200);
      chk("tol_done_cnt", done_cnt, exp_done);
      chk("tol_err", cap_err, 1);
      chk("tol_locked", cap_locked, 0);
      chk("tol_baud_kept", baud, 4800);
      chk("tol_bit_cycles_kept", bit_cycles, 2083);

      // lock at 115200, then 0x00 forces a timeout after edge 1
      arm();
      chk("err_cleared_by_start", err, 0);
      exp_done++;
      send_byte(8'h55, 86);
      wait_done(200);
      chk("relock_locked", locked, 1);
      arm();
      chk("locked_cleared_by_start", locked, 0);
      exp_done++;
      send_byte(8'h00, 86);
      wait_done(3000);
      chk("tmo_done_cnt", done_cnt, exp_done);
      chk("tmo_err", cap_err, 1);
      chk("tmo_locked", cap_locked, 0);
      chk("tmo_baud_kept", baud, 115200);
      chk("tmo_busy", busy, 0);

      // reset in the middle of a 38400 measurement
      arm();
      fork
         send_byte(8'h55, 260);
         begin
            repeat (780) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_busy", busy, 0);
            chk("midrst_baud", baud, 9600);
            chk("midrst_locked", locked, 0);
            chk("midrst_err", err, 0);
            chk("midrst_bit_cycles", bit_cycles, 0);
            rst = 1'b0;
         end
      join
      chk("midrst_no_done", done_cnt, exp_done);
      repeat (5) @(negedge clk);
      arm();
      exp_done++;
      send_byte(8'h55, 260);
      wait_done(200);
      chk("b38400_done_cnt", done_cnt, exp_done);
      chk("b38400_baud", cap_baud, 38400);
      chk("b38400_locked", cap_locked, 1);
      chk("b38400_bit_cycles", bit_cycles, 260);

      // one-cycle low glitch while waiting for the start bit, then 0x55 at 57600
      arm();
      repeat (20) @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      exp_done++;
      send_byte(8'h55, 173);
      wait_done(200);
      chk("glitch_done_cnt", done_cnt, exp_done);
`ifdef AUTOBAUD_GLITCH_FILTER_EN
      chk("glitch_baud", cap_baud, 57600);
      chk("glitch_locked", cap_locked, 1);
      chk("glitch_err", cap_err, 0);
      chk("glitch_bit_cycles", bit_cycles, 173);
`else
      chk("glitch_err", cap_err, 1);
      chk("glitch_locked", cap_locked, 0);
      chk("glitch_baud_kept", baud, 38400);
      chk("glitch_bit_cycles_kept", bit_cycles, 260);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Receiver-side baud-rate detector for the UART subsystem. It measures an incoming 0x55 sync character (8N1, LSB first) on the serial line and reports the matching standard rate as a 17-bit `baud` value. That value drives the `baud` input of the clock generator, so the local TX/RX clocks lock to the remote transmitter. The block runs entirely on the system clock and sits between the line pin and the UART top.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000: system clock frequency; sets the nominal cycles per bit for each supported rate.
- `CNT_W`, default 15: interval counter width. The total-span counter is `CNT_W+4` bits wide.
- `TIMEOUT_CYC`, default 25000: maximum cycles allowed between consecutive edges during measurement.

Ports:
- `clk`, in, 1: system clock. One clock domain; reset is asynchronous and active-high.
- `rst`, in, 1: asynchronous active-high reset.
- `rx`, in, 1: asynchronous serial line, idle high. Internally synchronized with 2 flops.
- `start`, in, 1: single-cycle pulse that arms detection. Ignored while `busy`=1.
- `busy`, out, 1: high from an accepted `start` until `done`.
- `done`, out, 1: single-cycle pulse when detection ends, on success or error.
- `locked`, out, 1: high after a successful detection. Cleared by `start`, `err` or reset.
- `err`, out, 1: high after a failed detection. Sticky until the next accepted `start`.
- `baud`, out, 17: detected rate. One of 4800, 9600, 14400, 19200, 38400, 57600, 115200, 128000.
- `bit_cycles`, out, `CNT_W`: measured cycles per bit.

## Operation
- States: IDLE → WAIT_HIGH → WAIT_FALL → MEASURE → EVAL → IDLE.
- IDLE: an accepted `start` sets `busy`, clears `locked` and `err`, and moves to WAIT_HIGH.
- WAIT_HIGH: wait until the filtered line is 1. This discards a character already in progress.
- WAIT_FALL: wait for the first falling edge (the start bit). There is no timeout in this state.
- MEASURE:
  - 0x55 produces 10 edges: falling edges at bit positions 0, 2, 4, 6, 8 and rising edges at 1, 3, 5, 7, 9.
  - The interval counter restarts on every edge.
  - The total counter runs from edge 0 to edge 8 (falling edge #5), which spans exactly 8 bit times.
  - Interval 0→1 is stored as `ref`.
  - Every later interval, including 8→9 (the rising edge into the stop bit), must lie within `ref ± ref/4`.
  - Any out-of-window interval sets error.
  - If the interval counter reaches `TIMEOUT_CYC` with no edge, that sets error.
- EVAL:
  - `bit_cycles = (total + 4) >> 3`, i.e. divide by 8 with rounding.
  - Select the rate whose nominal `CLK_FREQ_HZ/rate` is nearest to `bit_cycles`. The decision thresholds are the arithmetic midpoints between adjacent nominals.
  - If `|bit_cycles − nominal| > nominal/16`, the result is an error.
- On success: update `baud` and `bit_cycles`, set `locked`=1, pulse `done`.
- On error (from any state): `err`=1, `locked`=0, pulse `done`. `baud` and `bit_cycles` keep their previous values.
- Arithmetic: all counters are unsigned and saturate, never wrap. The total counter saturating is treated as a timeout.

## Timing
- Reset values: `busy`=0, `done`=0, `locked`=0, `err`=0, `baud`=9600 (17'd9600), `bit_cycles`=0, state IDLE.
- `start` is sampled on a rising `clk` edge. `busy` rises the next cycle.
- Line-to-edge-detect latency: 3 cycles (2-flop synchronizer plus edge register). The filter adds 2 more cycles. The latency is identical for every edge, so the measurement is unbiased.
- Edge 9 is detected in MEASURE. EVAL takes 1 cycle. `done`, `baud`, `locked` and `err` update together on the following cycle, and `busy` falls in that same cycle.
- A `start` pulse in the same cycle as `done` is ignored.
- Reset asserted mid-operation immediately forces all reset values and discards the measurement.

## Configuration
- `AUTOBAUD_GLITCH_FILTER_EN` defined:
  - The synchronized line passes through a 3-sample majority filter before edge detection.
  - A low or high pulse of 1 cycle is rejected.
  - Adds 2 cycles of latency.
- Undefined: the synchronized sample feeds edge detection directly, and a single-cycle glitch counts as an edge.

## Test plan
- 0x55 at 115200 (868 cyc/bit at 100 MHz) → `baud`=115200, `bit_cycles`=868, `locked`=1, one-cycle `done`, `err`=0.
- 0x55 at 4800 (20833 cyc/bit) → `baud`=4800, `bit_cycles`=20833, `locked`=1.
- 0x55 at 10104 cyc/bit (9600 running 3% fast) → `baud`=9600, `locked`=1.
- Prior lock at 115200, then 0x00 sent:
  - The interval 0→1 spans 9 bits and edge 2 never arrives → timeout.
  - Required response: `err`=1, `locked`=0, `done` pulse, `baud` stays 115200.
- Reset during MEASURE at 38400 → outputs return to reset values (`baud`=9600, `busy`=0). A following `start` plus 0x55 at 38400 gives `baud`=38400.
- A 1-cycle low glitch on `rx` during WAIT_FALL, then 0x55 at 57600:
  - With `AUTOBAUD_GLITCH_FILTER_EN`: `baud`=57600, `locked`=1.
  - Without it: `err`=1.
